// File: rtl/bch_chien_search_pkg.sv
// GF(2^m) definitions shared by the BCH syndrome, Berlekamp-Massey and Chien stages.
// Tables and constant multipliers are resolved at elaboration time.
package bch_chien_search_pkg;
  localparam int m  = 4;
  localparam int n  = (1 << m) - 1;
  localparam int t  = 2;
  localparam int t2 = 2 * t;

  localparam logic [m:0] PRIM_POLY = 5'b10011;  // x^4 + x + 1

  typedef logic [m-1:0] data_t;
  typedef data_t [n:0]  gf_tab_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } chien_state_t;

  localparam data_t PRIM_RED = PRIM_POLY[m-1:0];

  // Polynomial-basis multiply: shift-and-add with modular reduction.
  function automatic data_t gf_mul(input data_t a, input data_t b);
    data_t p;
    data_t aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < m; k++) begin
      if (b[k]) p = p ^ aa;
      aa = aa[m-1] ? ((aa << 1) ^ PRIM_RED) : (aa << 1);
    end
    return p;
  endfunction

  function automatic data_t alpha_pow(input int e);
    data_t r;
    r = data_t'(1);
    for (int k = 0; k < (e % n); k++) r = gf_mul(r, data_t'(2));
    return r;
  endfunction

  function automatic gf_tab_t gen_alpha_to();
    gf_tab_t tab;
    for (int k = 0; k < n; k++) tab[k] = alpha_pow(k);
    tab[n] = '0;
    return tab;
  endfunction

  // Index n stands in for log(0).
  function automatic gf_tab_t gen_index_of();
    gf_tab_t tab;
    tab    = '0;
    tab[0] = data_t'(n);
    for (int k = 0; k < n; k++) tab[alpha_pow(k)] = data_t'(k);
    return tab;
  endfunction

  localparam gf_tab_t ALPHA_TO = gen_alpha_to();
  localparam gf_tab_t INDEX_OF = gen_index_of();
endpackage

// File: rtl/bch_chien_term.sv
// One Chien term register T_i: loaded as lambda_i * alpha^(i*(n-N_CODE+1)),
// then stepped by alpha^i each search cycle.
module bch_chien_term
  import bch_chien_search_pkg::*;
#(
  parameter int I      = 0,
  parameter int N_CODE = n
) (
  input  logic  iclk,
  input  logic  ireset,
  input  logic  iload,
  input  logic  ien,
  input  data_t ilambda,
  output data_t oterm
);
  // Load offset skips the positions removed by shortening.
  localparam data_t LOAD_C = ALPHA_TO[(I * (n - N_CODE + 1)) % n];
  localparam data_t STEP_C = ALPHA_TO[I % n];

  data_t term;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset)    term <= '0;
    else if (iload) term <= gf_mul(ilambda, LOAD_C);
    else if (ien)   term <= gf_mul(term, STEP_C);
  end

  assign oterm = term;
endmodule

// File: rtl/bch_chien_search.sv
// Serial Chien search: one codeword position per clock, highest index first,
// followed by a root-count / decoder-fail report.
module bch_chien_search
  import bch_chien_search_pkg::*;
#(
  parameter int N_CODE = n
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic          iloc_poly_val,
  input  data_t [t:0]   iloc_poly,
  input  data_t         iloc_poly_deg,
  input  logic          iloc_failed,
  output logic          obusy,
  output logic          oerr_val,
  output logic          oerr,
  output logic          osop,
  output logic          oeop,
  output logic          odone,
  output data_t         oerr_cnt,
  output logic          odecfail
);
  localparam data_t LAST = data_t'(N_CODE - 1);

  chien_state_t state;
  data_t [t:0]  term;
  data_t        sum;
  data_t        step;
  data_t        root_cnt;
  data_t        deg_q;
  logic         failed_q;
  logic         load;
  logic         en;
  logic         zero;

  assign load = (state == IDLE) && iloc_poly_val;
  assign en   = (state == SEARCH);

  for (genvar i = 0; i <= t; i++) begin : g_term
    bch_chien_term #(.I(i), .N_CODE(N_CODE)) u_term (
      .iclk    (iclk),
      .ireset  (ireset),
      .iload   (load),
      .ien     (en),
      .ilambda (iloc_poly[i]),
      .oterm   (term[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= t; i++) sum = sum ^ term[i];
  end

  assign zero = (sum == '0);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state    <= IDLE;
      obusy    <= 1'b0;
      oerr_val <= 1'b0;
      oerr     <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      odone    <= 1'b0;
      oerr_cnt <= '0;
      odecfail <= 1'b0;
      step     <= '0;
      root_cnt <= '0;
      deg_q    <= '0;
      failed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          odone    <= 1'b0;
          oerr_val <= 1'b0;
          oerr     <= 1'b0;
          osop     <= 1'b0;
          oeop     <= 1'b0;
          if (iloc_poly_val) begin
            obusy    <= 1'b1;
            deg_q    <= iloc_poly_deg;
            failed_q <= iloc_failed;
            root_cnt <= '0;
            step     <= '0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          oerr_val <= 1'b1;
          oerr     <= zero;
          osop     <= (step == '0);
          oeop     <= (step == LAST);
          if (zero) root_cnt <= root_cnt + data_t'(1);
          step <= step + data_t'(1);
          if (step == LAST) state <= DONE;
        end
        DONE: begin
          // Results latch here and hold until the next search completes.
          oerr_val <= 1'b0;
          oerr     <= 1'b0;
          osop     <= 1'b0;
          oeop     <= 1'b0;
          odone    <= 1'b1;
          obusy    <= 1'b0;
          oerr_cnt <= root_cnt;
          odecfail <= failed_q | (root_cnt != deg_q);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
